sched_request_arbiter: RTL and testbench
========================================

# sched_request_arbiter

Serialises schedule/deschedule requests from core 0, core 1 and the channel controller onto the single-operation enable/finished handshake of the Scheduler. It sits between the two cores plus the channel controller and the Scheduler. Only one Scheduler operation is in flight at a time. Requesters are served round-robin and each receives a one-cycle acknowledge when its operation has completed.

## Interface

Parameters:
- addrBits, 16, pid width; equals the Scheduler's addrBits

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- core0Req  in  1  core 0 request, held until core0Ack
- core0HasDeschedule  in  1  request deschedules core0DeschedulePid
- core0DeschedulePid  in  addrBits  pid to deschedule
- core0HasSchedule  in  1  request schedules core0SchedulePid
- core0SchedulePid  in  addrBits  pid to schedule
- core0Ack  out  1  one-cycle pulse: operation complete
- core1Req, core1HasDeschedule, core1DeschedulePid, core1HasSchedule, core1SchedulePid, core1Ack: as core 0
- chanReq  in  1  channel controller wake request (schedule only)
- chanSchedulePid  in  addrBits  pid to make ready
- chanAck  out  1  one-cycle completion pulse
- schedEnabled  out  1  Scheduler enabled
- schedFinished  in  1  Scheduler finished
- schedHasDeschedule  out  1  to Scheduler hasDeschedule
- schedDeschedulePid  out  addrBits  to Scheduler deschedulePid
- schedHasSchedule  out  1  to Scheduler hasSchedule
- schedSchedulePid  out  addrBits  to Scheduler schedulePid
- busy  out  1  state != IDLE

## Operation

Requester indices: 0 = core0, 1 = core1, 2 = chan. The channel request presents hasDeschedule=0 and hasSchedule=1.

States:
- **IDLE**: if no req, stay in IDLE.
  - Otherwise pick the winner round-robin, starting from the requester after lastGrant.
  - Latch the winner's flags and pids into the sched* registers.
  - Set grant to the winner and lastGrant to the winner.
  - If the winner has neither flag: go to ACK.
  - Otherwise: set schedEnabled to 1 and go to RUN.
- **RUN**: hold schedEnabled and all sched* outputs stable.
  - When schedFinished = 1: set schedEnabled to 0 and go to ACK.
  - There is no timeout.
- **ACK**: pulse the Ack of the grantee for exactly one cycle and go to RELEASE.
- **RELEASE**: wait for schedFinished = 0, then go to IDLE.
  - This guarantees the Scheduler sees enabled low before it is re-enabled.

Rules:
- The sched* pid and flag outputs are registered. They change only on an IDLE→RUN or IDLE→ACK transition and otherwise keep their last value.
- Requester contract:
  - Hold req, flags and pids stable from req assertion until Ack is sampled.
  - Deassert req on the same edge that samples Ack.
  - req is sampled only in IDLE, so a stale req is never double-served.
- The arbiter never issues an operation that combines two requesters. A core's deschedule plus schedule pair (fork or channel hand-off) goes to the Scheduler as one combined operation.
- Simultaneous requests: exactly one is granted per pass through IDLE. The others wait with req held.
- Starvation bound: a waiting requester is granted within 2 further operations.
- An Ack can never coincide with schedEnabled = 1.

## Timing

- Reset values: all Acks 0, schedEnabled 0, sched* flags and pids 0, busy 0, state IDLE, lastGrant = 2 (so core0 has first priority).
- Grant latency: req high at edge E in IDLE gives schedEnabled = 1 and valid sched* outputs after E.
- Completion: schedFinished sampled high at edge F gives schedEnabled = 0 after F and Ack = 1 for the cycle after F+1.
- Minimum turnaround:
  - A flagless request is acked 2 cycles after grant. IDLE again at the earliest 3 cycles after grant.
  - A Scheduler operation adds ACK plus at least one RELEASE cycle after finished.
- Reset mid-operation: return to IDLE the next cycle with schedEnabled = 0. No Ack is issued and the pending operation is dropped. The Scheduler shares the reset, and requesters must re-request.

## Structure

- Shared package, sched_arb_pkg:
  - state enum IDLE/RUN/ACK/RELEASE
  - requester index constants REQ_CORE0 = 0, REQ_CORE1 = 1, REQ_CHAN = 2
  - NUM_REQ = 3
- Sub-module rr_pick3: combinational round-robin picker.
  - Inputs: 3-bit req vector, lastGrant index.
  - Outputs: valid, grant index.
  - Verified standalone.
- The top-level holds the FSM, the latched operation registers and lastGrant.

## Test plan

- Reset, then core0Req with hasSchedule=1, pid 1; model finished 3 cycles after enable → schedHasSchedule=1, schedSchedulePid=1; schedEnabled high until finished; one core0Ack pulse; chanAck and core1Ack stay 0.
- core0, core1 and chan all request in the same cycle with pids 5, 6, 7 → grant order core0, core1, chan. The next simultaneous burst starts at core0 again after chan. The Scheduler never sees enabled rise while finished is high.
- core1 requests deschedule 2 plus schedule 4 → a single operation with schedHasDeschedule=1, schedDeschedulePid=2, schedHasSchedule=1, schedSchedulePid=4; exactly one core1Ack.
- Flagless core0 request → core0Ack 2 cycles after grant; schedEnabled never asserts.
- Model holds finished high for 4 cycles after enabled drops → the arbiter stays in RELEASE; a new chanReq is not granted until finished is low.
- Reset asserted during RUN → schedEnabled 0 and busy 0 the next cycle; no Ack; a fresh request afterwards is served normally.

Source files
------------

// File: rtl/sched_arb_pkg.sv
// Shared types and requester indices for the scheduler request arbiter.
package sched_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_CORE0 = 2'd0;
    localparam logic [1:0] REQ_CORE1 = 2'd1;
    localparam logic [1:0] REQ_CHAN  = 2'd2;

    // Round-robin successor; wraps chan back to core0.
    function automatic logic [1:0] next_req(input logic [1:0] idx);
        return (idx >= REQ_CHAN) ? REQ_CORE0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker over three requesters, searching from the
// requester after last_grant.
module rr_pick3
    import sched_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_grant,
    output logic               valid,
    output logic [1:0]         grant
);

    logic [1:0] cand;

    always_comb begin
        valid = 1'b0;
        grant = last_grant;
        cand  = last_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = next_req(cand);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/sched_request_arbiter.sv
// Serialises core0/core1/channel schedule requests onto the Scheduler's
// single enable/finished handshake, one operation at a time, round-robin.
//
// state   | meaning
// IDLE    | sample requests, latch winner's operation
// RUN     | Scheduler enabled, waiting for finished
// ACK     | raise the grantee's ack for one cycle
// RELEASE | wait for finished low before allowing a new grant
module sched_request_arbiter
    import sched_arb_pkg::*;
#(
    parameter int addrBits = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core0Req,
    input  logic                core0HasDeschedule,
    input  logic [addrBits-1:0] core0DeschedulePid,
    input  logic                core0HasSchedule,
    input  logic [addrBits-1:0] core0SchedulePid,
    output logic                core0Ack,
    input  logic                core1Req,
    input  logic                core1HasDeschedule,
    input  logic [addrBits-1:0] core1DeschedulePid,
    input  logic                core1HasSchedule,
    input  logic [addrBits-1:0] core1SchedulePid,
    output logic                core1Ack,
    input  logic                chanReq,
    input  logic [addrBits-1:0] chanSchedulePid,
    output logic                chanAck,
    output logic                schedEnabled,
    input  logic                schedFinished,
    output logic                schedHasDeschedule,
    output logic [addrBits-1:0] schedDeschedulePid,
    output logic                schedHasSchedule,
    output logic [addrBits-1:0] schedSchedulePid,
    output logic                busy
);

    state_t              state;
    logic [1:0]          grant_idx;
    logic [1:0]          last_grant;
    logic [NUM_REQ-1:0]  ack_q;

    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic                win_hd;
    logic [addrBits-1:0] win_dp;
    logic                win_hs;
    logic [addrBits-1:0] win_sp;

    rr_pick3 u_pick (
        .req        ({chanReq, core1Req, core0Req}),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick_idx)
    );

    // The channel controller only ever wakes a process: schedule without deschedule.
    always_comb begin
        win_hd = 1'b0;
        win_dp = '0;
        win_hs = 1'b0;
        win_sp = '0;
        case (pick_idx)
            REQ_CORE0: begin
                win_hd = core0HasDeschedule;
                win_dp = core0DeschedulePid;
                win_hs = core0HasSchedule;
                win_sp = core0SchedulePid;
            end
            REQ_CORE1: begin
                win_hd = core1HasDeschedule;
                win_dp = core1DeschedulePid;
                win_hs = core1HasSchedule;
                win_sp = core1SchedulePid;
            end
            REQ_CHAN: begin
                win_hs = 1'b1;
                win_sp = chanSchedulePid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            grant_idx          <= REQ_CORE0;
            last_grant         <= REQ_CHAN;
            ack_q              <= '0;
            schedEnabled       <= 1'b0;
            schedHasDeschedule <= 1'b0;
            schedDeschedulePid <= '0;
            schedHasSchedule   <= 1'b0;
            schedSchedulePid   <= '0;
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        schedHasDeschedule <= win_hd;
                        schedDeschedulePid <= win_dp;
                        schedHasSchedule   <= win_hs;
                        schedSchedulePid   <= win_sp;
                        grant_idx          <= pick_idx;
                        last_grant         <= pick_idx;
                        if (!win_hd && !win_hs) begin
                            state <= ACK;
                        end else begin
                            schedEnabled <= 1'b1;
                            state        <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (schedFinished) begin
                        schedEnabled <= 1'b0;
                        state        <= ACK;
                    end
                end
                ACK: begin
                    ack_q <= 3'b001 << grant_idx;
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!schedFinished) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign core0Ack = ack_q[REQ_CORE0];
    assign core1Ack = ack_q[REQ_CORE1];
    assign chanAck  = ack_q[REQ_CHAN];
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sched_request_arbiter.sv
// Scoreboard bench for sched_request_arbiter: stimulus queues the expected
// operation per ack, a monitor pops and checks at every ack pulse.
module tb_sched_request_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core0Req = 0, core0HasDeschedule = 0, core0HasSchedule = 0;
    logic [15:0] core0DeschedulePid = 0, core0SchedulePid = 0;
    logic        core1Req = 0, core1HasDeschedule = 0, core1HasSchedule = 0;
    logic [15:0] core1DeschedulePid = 0, core1SchedulePid = 0;
    logic        chanReq = 0;
    logic [15:0] chanSchedulePid = 0;
    logic        core0Ack, core1Ack, chanAck;
    logic        schedEnabled, schedHasDeschedule, schedHasSchedule, busy;
    logic        schedFinished = 1'b0;
    logic [15:0] schedDeschedulePid, schedSchedulePid;

    sched_request_arbiter #(.addrBits(16)) dut (
        .clk(clk), .reset(reset),
        .core0Req(core0Req), .core0HasDeschedule(core0HasDeschedule),
        .core0DeschedulePid(core0DeschedulePid), .core0HasSchedule(core0HasSchedule),
        .core0SchedulePid(core0SchedulePid), .core0Ack(core0Ack),
        .core1Req(core1Req), .core1HasDeschedule(core1HasDeschedule),
        .core1DeschedulePid(core1DeschedulePid), .core1HasSchedule(core1HasSchedule),
        .core1SchedulePid(core1SchedulePid), .core1Ack(core1Ack),
        .chanReq(chanReq), .chanSchedulePid(chanSchedulePid), .chanAck(chanAck),
        .schedEnabled(schedEnabled), .schedFinished(schedFinished),
        .schedHasDeschedule(schedHasDeschedule), .schedDeschedulePid(schedDeschedulePid),
        .schedHasSchedule(schedHasSchedule), .schedSchedulePid(schedSchedulePid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        hd;
        logic [15:0] dp;
        logic        hs;
        logic [15:0] sp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   en_cnt = 0;
    int   fin_delay = 3;
    int   fin_hold = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scheduler model: finishes fin_delay cycles after enable, holds finished
    // fin_hold extra cycles after enable drops.
    int fin_cnt = 0;
    int hold_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            fin_cnt = 0;
            hold_cnt = 0;
            schedFinished = 1'b0;
        end else if (schedEnabled && !schedFinished) begin
            fin_cnt++;
            if (fin_cnt >= fin_delay) begin
                schedFinished = 1'b1;
                fin_cnt = 0;
                hold_cnt = 0;
            end
        end else if (schedFinished && !schedEnabled) begin
            if (hold_cnt >= fin_hold) schedFinished = 1'b0;
            else hold_cnt++;
        end
    end

    // Monitor: scoreboard pop on each ack, plus handshake invariants.
    logic [2:0] prev_acks = 3'b000;
    logic       prev_en = 1'b0;
    always @(posedge clk) begin
        logic [2:0] acks;
        exp_t e;
        #2;
        acks = {chanAck, core1Ack, core0Ack};
        if (schedEnabled) en_cnt++;
        if (schedEnabled && !prev_en) chk("enable_rise_while_finished", schedFinished, 0);
        if (acks != 3'b000) begin
            chk("ack_with_enable", schedEnabled, 0);
            chk("ack_pulse_width", prev_acks & acks, 0);
            if (q.size() == 0) begin
                chk("ack_unexpected", acks, 0);
            end else begin
                e = q.pop_front();
                chk("ack_who", acks, 3'b001 << e.idx);
                chk("op_hasDeschedule", schedHasDeschedule, e.hd);
                chk("op_deschedulePid", schedDeschedulePid, e.dp);
                chk("op_hasSchedule", schedHasSchedule, e.hs);
                chk("op_schedulePid", schedSchedulePid, e.sp);
            end
        end
        prev_acks = acks;
        prev_en = schedEnabled;
    end

    task automatic set_req(input int idx, input logic r, input logic hd, input logic [15:0] dp,
                           input logic hs, input logic [15:0] sp);
        case (idx)
            0: begin core0Req = r; core0HasDeschedule = hd; core0DeschedulePid = dp;
                     core0HasSchedule = hs; core0SchedulePid = sp; end
            1: begin core1Req = r; core1HasDeschedule = hd; core1DeschedulePid = dp;
                     core1HasSchedule = hs; core1SchedulePid = sp; end
            default: begin chanReq = r; chanSchedulePid = sp; end
        endcase
    endtask

    task automatic req_op(input int idx, input logic hd, input logic [15:0] dp,
                          input logic hs, input logic [15:0] sp);
        logic got = 1'b0;
        @(negedge clk);
        set_req(idx, 1'b1, hd, dp, hs, sp);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            got = (idx == 0) ? core0Ack : (idx == 1) ? core1Ack : chanAck;
            if (got) break;
        end
        chk($sformatf("ack_timeout_req%0d", idx), got, 1);
        set_req(idx, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic released;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_enabled", schedEnabled, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {chanAck, core1Ack, core0Ack}, 0);
        chk("rst_flags", {schedHasDeschedule, schedHasSchedule}, 0);
        chk("rst_pids", {schedDeschedulePid, schedSchedulePid}, 0);

        // Single core0 schedule, finished 3 cycles after enable.
        en_cnt = 0;
        q.push_back('{0, 1'b0, 16'd0, 1'b1, 16'd1});
        req_op(0, 1'b0, 16'd0, 1'b1, 16'd1);
        chk("t1_enable_cycles", en_cnt, 3);

        // Reset restores core0 first priority, then two simultaneous bursts.
        pulse_reset();
        q.push_back('{0, 1'b0, 16'd0, 1'b1, 16'd5});
        q.push_back('{1, 1'b0, 16'd0, 1'b1, 16'd6});
        q.push_back('{2, 1'b0, 16'd0, 1'b1, 16'd7});
        fork
            req_op(0, 1'b0, 16'd0, 1'b1, 16'd5);
            req_op(1, 1'b0, 16'd0, 1'b1, 16'd6);
            req_op(2, 1'b0, 16'd0, 1'b1, 16'd7);
        join
        q.push_back('{0, 1'b1, 16'd10, 1'b1, 16'd11});
        q.push_back('{1, 1'b0, 16'd0, 1'b1, 16'd12});
        q.push_back('{2, 1'b0, 16'd0, 1'b1, 16'd13});
        fork
            req_op(0, 1'b1, 16'd10, 1'b1, 16'd11);
            req_op(1, 1'b0, 16'd0, 1'b1, 16'd12);
            req_op(2, 1'b0, 16'd0, 1'b1, 16'd13);
        join

        // core1 combined deschedule 2 + schedule 4.
        q.push_back('{1, 1'b1, 16'd2, 1'b1, 16'd4});
        req_op(1, 1'b1, 16'd2, 1'b1, 16'd4);

        // Flagless core0: ack two edges after the request is sampled, no enable.
        en_cnt = 0;
        q.push_back('{0, 1'b0, 16'd9, 1'b0, 16'd8});
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 16'd9, 1'b0, 16'd8);
        @(negedge clk);
        chk("flagless_ack_early", core0Ack, 0);
        chk("flagless_busy", busy, 1);
        @(negedge clk);
        chk("flagless_ack", core0Ack, 1);
        set_req(0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
        repeat (2) @(negedge clk);
        chk("flagless_enable_cycles", en_cnt, 0);

        // Finished held after enable drops: chan must wait in RELEASE.
        fin_hold = 4;
        q.push_back('{0, 1'b0, 16'd0, 1'b1, 16'd3});
        q.push_back('{2, 1'b0, 16'd0, 1'b1, 16'd14});
        req_op(0, 1'b0, 16'd0, 1'b1, 16'd3);
        fork
            req_op(2, 1'b0, 16'd0, 1'b1, 16'd14);
            begin
                released = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (!schedFinished) begin released = 1'b1; break; end
                    chk("release_no_enable", schedEnabled, 0);
                    chk("release_busy", busy, 1);
                end
                chk("release_timeout", released, 1);
            end
        join
        fin_hold = 0;

        // Reset during RUN drops the operation without an ack.
        fin_delay = 100;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 16'd0, 1'b1, 16'd20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (schedEnabled) break;
        end
        chk("mid_run_enabled", schedEnabled, 1);
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
        @(negedge clk);
        chk("mid_rst_enabled", schedEnabled, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ack", core0Ack, 0);
        reset = 1'b0;
        fin_delay = 3;
        q.push_back('{0, 1'b0, 16'd0, 1'b1, 16'd21});
        req_op(0, 1'b0, 16'd0, 1'b1, 16'd21);

        repeat (6) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
